// File: rtl/ag_sram_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// ag_sram_burst_ctrl_if
// Handshake/data bundle between a burst requester and ag_sram_burst_ctrl.
//
// Signals (widths follow the controller's derived parameters):
//   enable      requester -> ctrl  start request (sampled only while idle)
//   rw_mode     requester -> ctrl  0 = write burst, 1 = read burst
//   slot        requester -> ctrl  target slot, SLOT_W bits
//   write_data  requester -> ctrl  one word per write beat
//   busy        ctrl -> requester  burst in progress (WRITE/READ/DONE)
//   done        ctrl -> requester  one-cycle completion pulse
//   read_valid  ctrl -> requester  read_data holds a word this cycle
//   read_data   ctrl -> requester  registered read word
//   addr        ctrl -> requester  current SRAM address (debug)
//   slot_err    ctrl -> requester  one-cycle pulse, start rejected
//   parity_err  ctrl -> requester  read parity mismatch, qualified by read_valid
//
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface ag_sram_burst_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int SLOT_W = 2,
  parameter int ADDR_W = 5
) ();

  logic              enable;
  logic              rw_mode;
  logic [SLOT_W-1:0] slot;
  logic [DATA_W-1:0] write_data;
  logic              busy;
  logic              done;
  logic              read_valid;
  logic [DATA_W-1:0] read_data;
  logic [ADDR_W-1:0] addr;
  logic              slot_err;
  logic              parity_err;

  modport master (
    output enable, rw_mode, slot, write_data,
    input  busy, done, read_valid, read_data, addr, slot_err, parity_err
  );

  modport slave (
    input  enable, rw_mode, slot, write_data,
    output busy, done, read_valid, read_data, addr, slot_err, parity_err
  );

endinterface

// File: rtl/ag_sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// ag_sram_burst_ctrl
// Address generator plus on-chip SRAM used as a block buffer. A single enable
// pulse while idle starts a BURST_LEN-word write or read burst to one of
// NUM_SLOTS slots. The SRAM is synchronous with one cycle of read latency.
//
// Ports:
//   clk   clock, all logic on the rising edge
//   rst   asynchronous, active-high reset (SRAM contents are kept)
//   bus   ag_sram_burst_ctrl_if.slave : enable, rw_mode, slot, write_data in;
//         busy, done, read_valid, read_data, addr, slot_err, parity_err out
//
// Optional feature (macro AG_SRAM_PARITY_EN):
//   defined   - each SRAM word carries an even-parity bit of the written data;
//               a read word whose stored parity disagrees raises parity_err
//               alongside read_valid.
//   undefined - SRAM is DATA_W bits wide and parity_err is tied low.
// -----------------------------------------------------------------------------
module ag_sram_burst_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 8,
  parameter int NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ag_sram_burst_ctrl_if.slave  bus
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int ADDR_W = $clog2(NUM_SLOTS * BURST_LEN);
  localparam int DEPTH  = NUM_SLOTS * BURST_LEN;
  localparam int BEAT_W = $clog2(BURST_LEN);

`ifdef AG_SRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // One extra bit so NUM_SLOTS itself is representable when it is a power of 2.
  localparam logic [SLOT_W:0] NUM_SLOTS_L = (SLOT_W + 1)'(NUM_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } state_e;

  state_e            state_q;
  logic [SLOT_W-1:0] slot_q;
  logic [BEAT_W-1:0] beat_q;
  logic              busy_q;
  logic              done_q;
  logic              read_valid_q;
  logic              slot_err_q;
  logic [DATA_W-1:0] read_data_q;

  logic [ADDR_W-1:0] addr;
  logic              last_beat;
  logic              slot_ok;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  logic [MEM_W-1:0]  mem [DEPTH];

  // Address is always inside the latched slot: the beat counter is cleared
  // on the last beat, so it can never carry into the neighbouring slot.
  assign addr      = ADDR_W'(slot_q) * ADDR_W'(BURST_LEN) + ADDR_W'(beat_q);
  assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign slot_ok   = ({1'b0, bus.slot} < NUM_SLOTS_L);
  assign rd_word   = mem[addr];

`ifdef AG_SRAM_PARITY_EN
  // Even parity: stored bit makes the total number of ones even.
  assign wr_word = {^bus.write_data, bus.write_data};
`else
  assign wr_word = bus.write_data;
`endif

  // NOTE: the SRAM array has no reset on purpose; contents must survive rst,
  // and a reset port would stop the array mapping onto a RAM macro. Writes
  // stop at once on reset because they are gated by the reset FSM state.
  always_ff @(posedge clk) begin
    if (state_q == ST_WRITE) begin
      mem[addr] <= wr_word;
    end
  end

`ifdef AG_SRAM_PARITY_EN
  logic parity_err_q;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      beat_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      read_valid_q <= 1'b0;
      slot_err_q   <= 1'b0;
      read_data_q  <= '0;
`ifdef AG_SRAM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; the state that owns them raises them.
      done_q       <= 1'b0;
      read_valid_q <= 1'b0;
      slot_err_q   <= 1'b0;
`ifdef AG_SRAM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (bus.enable) begin
            if (slot_ok) begin
              slot_q  <= bus.slot;
              beat_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= bus.rw_mode ? ST_READ : ST_WRITE;
            end else begin
              slot_err_q <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (last_beat) begin
            beat_q  <= '0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end

        ST_READ: begin
          // Word addressed this cycle appears on read_data next cycle.
          read_data_q  <= rd_word[DATA_W-1:0];
          read_valid_q <= 1'b1;
`ifdef AG_SRAM_PARITY_EN
          parity_err_q <= rd_word[DATA_W] ^ (^rd_word[DATA_W-1:0]);
`endif
          if (last_beat) begin
            beat_q  <= '0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.read_valid = read_valid_q;
  assign bus.read_data  = read_data_q;
  assign bus.addr       = addr;
  assign bus.slot_err   = slot_err_q;
`ifdef AG_SRAM_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ag_sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ag_sram_burst_ctrl
// Directed bench for ag_sram_burst_ctrl. u_dut uses the default 4 slots;
// u_dut3 uses 3 slots to exercise start rejection for slot >= NUM_SLOTS.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Burst data is packed 64-bit, word 0 in the most significant byte.
// -----------------------------------------------------------------------------
module tb_ag_sram_burst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ag_sram_burst_ctrl_if #(.DATA_W(8), .SLOT_W(2), .ADDR_W(5)) bus  ();
  ag_sram_burst_ctrl_if #(.DATA_W(8), .SLOT_W(2), .ADDR_W(5)) bus3 ();

  ag_sram_burst_ctrl #(.DATA_W(8), .BURST_LEN(8), .NUM_SLOTS(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ag_sram_burst_ctrl #(.DATA_W(8), .BURST_LEN(8), .NUM_SLOTS(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  localparam logic [63:0] D0 = 64'h90_1a_ed_f1_81_f8_68_b4;
  localparam logic [63:0] D1 = 64'h12_34_56_78_9a_bc_ed_f0;
  localparam logic [63:0] D3 = 64'h01_02_03_04_05_06_07_08;
  localparam logic [63:0] DZ = 64'h00_00_00_00_00_00_00_00;
  localparam logic [63:0] DA = 64'haa_aa_aa_aa_aa_aa_aa_aa;
  localparam logic [63:0] DP = 64'haa_aa_aa_00_00_00_00_00;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] word_k(input logic [63:0] v, input int k);
    return v[8*(7-k) +: 8];
  endfunction

  // Runs one burst on u_dut starting in the current cycle (S) and returns in
  // cycle S+10. With hold_en the enable stays high throughout, rw_mode/slot
  // are scrambled from S+3, and enable is still high on return.
  task automatic burst(input bit rw, input logic [1:0] s, input logic [63:0] data,
                       input logic [7:0] pe, input bit hold_en);
    string nm;
    int    exp_addr;
    bit    vld;
    nm = $sformatf("%s s%0d", rw ? "rd" : "wr", s);
    check({nm, " idle at start"}, bus.busy, 0);
    bus.enable     = 1'b1;
    bus.rw_mode    = rw;
    bus.slot       = s;
    bus.write_data = 8'h3c;
    step();
    for (int c = 1; c <= 10; c++) begin
      bus.enable = hold_en;
      if (hold_en && (c == 3 || c == 9)) begin
        bus.rw_mode = ~rw;
        bus.slot    = s + 2'd1;
      end
      if (!rw && c <= 8) bus.write_data = word_k(data, c - 1);
      else               bus.write_data = 8'hc3;
      exp_addr = int'(s) * 8 + ((c <= 8) ? c - 1 : 0);
      vld      = rw && (c >= 2) && (c <= 9);
      check($sformatf("%s c%0d busy", nm, c), bus.busy, (c <= 9));
      check($sformatf("%s c%0d done", nm, c), bus.done, (c == 9));
      check($sformatf("%s c%0d addr", nm, c), bus.addr, exp_addr);
      check($sformatf("%s c%0d valid", nm, c), bus.read_valid, vld);
      if (vld) begin
        check($sformatf("%s c%0d data", nm, c), bus.read_data, word_k(data, c - 2));
        check($sformatf("%s c%0d perr", nm, c), bus.parity_err, pe[c-2]);
      end else begin
        check($sformatf("%s c%0d perr", nm, c), bus.parity_err, 0);
      end
      if (rw && c == 10) check({nm, " data held"}, bus.read_data, word_k(data, 7));
      if (c < 10) step();
    end
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.rw_mode     = 1'b0;
    bus.slot        = '0;
    bus.write_data  = '0;
    bus3.enable     = 1'b0;
    bus3.rw_mode    = 1'b0;
    bus3.slot       = '0;
    bus3.write_data = '0;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check("rst busy",   bus.busy,        0);
    check("rst done",   bus.done,        0);
    check("rst valid",  bus.read_valid,  0);
    check("rst data",   bus.read_data,   0);
    check("rst addr",   bus.addr,        0);
    check("rst slterr", bus.slot_err,    0);
    check("rst perr",   bus.parity_err,  0);
    check("rst3 busy",  bus3.busy,       0);
    check("rst3 addr",  bus3.addr,       0);
    rst = 1'b0;
    step();

    // Write then read slot 0.
    burst(1'b0, 2'd0, D0, 8'h00, 1'b0);
    burst(1'b1, 2'd0, D0, 8'h00, 1'b0);

    // Slot 1 written; slot 0 must be untouched.
    burst(1'b0, 2'd1, D1, 8'h00, 1'b0);
    burst(1'b1, 2'd0, D0, 8'h00, 1'b0);
    burst(1'b1, 2'd1, D1, 8'h00, 1'b0);

    // Enable held through a write to the last slot; the follow-on read is
    // accepted at S+10 and proves exactly one write burst took place.
    burst(1'b0, 2'd3, D3, 8'h00, 1'b1);
    burst(1'b1, 2'd3, D3, 8'h00, 1'b0);
    burst(1'b1, 2'd1, D1, 8'h00, 1'b0);

    // Out-of-range slot on the 3-slot instance.
    check("s3 pre busy", bus3.busy, 0);
    bus3.enable     = 1'b1;
    bus3.rw_mode    = 1'b0;
    bus3.slot       = 2'd3;
    bus3.write_data = 8'hff;
    step();
    bus3.enable = 1'b0;
    check("s3 slot_err", bus3.slot_err, 1);
    check("s3 busy",     bus3.busy,     0);
    check("s3 done",     bus3.done,     0);
    check("s3 addr",     bus3.addr,     0);
    step();
    check("s3 slot_err drop", bus3.slot_err, 0);
    check("s3 still idle",    bus3.busy,     0);
    // Highest legal slot on the same instance is accepted.
    bus3.enable  = 1'b1;
    bus3.rw_mode = 1'b1;
    bus3.slot    = 2'd2;
    step();
    bus3.enable = 1'b0;
    check("s2 busy",     bus3.busy,     1);
    check("s2 slot_err", bus3.slot_err, 0);
    check("s2 addr",     bus3.addr,     16);
    repeat (8) step();
    check("s2 done",     bus3.done,     1);
    step();
    check("s2 idle",     bus3.busy,     0);

    // Reset mid-write: slot 2 zeroed, then aa.. write aborted at S+4.
    burst(1'b0, 2'd2, DZ, 8'h00, 1'b0);
    check("abort pre busy", bus.busy, 0);
    bus.enable  = 1'b1;
    bus.rw_mode = 1'b0;
    bus.slot    = 2'd2;
    step();
    bus.enable     = 1'b0;
    bus.write_data = word_k(DA, 0);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("abort busy",  bus.busy,       0);
    check("abort done",  bus.done,       0);
    check("abort addr",  bus.addr,       0);
    check("abort valid", bus.read_valid, 0);
    check("abort data",  bus.read_data,  0);
    check("abort slerr", bus.slot_err,   0);
    step();
    rst = 1'b0;
    step();
    burst(1'b1, 2'd2, DP, 8'h00, 1'b0);

`ifdef AG_SRAM_PARITY_EN
    // Corrupt data bit 0 of slot 0 word 3 behind the parity bit.
    u_dut.mem[3][0] = ~u_dut.mem[3][0];
    burst(1'b1, 2'd0, 64'h90_1a_ed_f0_81_f8_68_b4, 8'h08, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
